// File: rtl/rx_drain_sched.sv
// rx_drain_sched: host-side scheduler for the RX DDR ring filled by the DMA write engine.
// It enables the writer, issues one packet-sized read request per available packet,
// retires each packet with a 4-phase tick/ack handshake and recovers from overflow
// by stopping the writer, discarding the ring and re-aligning both pointers to base.
// Ports:
//   aclk, aresetn                       clock, async active-low reset
//   run, stop_on_overflow               control levels
//   buffer_base_address, buffer_size,
//   buffer_packet_size_bytes            ring geometry
//   write_enable, write_state, buffer_empty, buffer_overflow, buffer_occupation,
//   buffer_packet_tick, buffer_packet_tick_ack    write-engine interface
//   xfer_req_valid/ready/addr/len, xfer_done, xfer_err    downstream DMA interface
//   sched_state, read_offset, packets_sent, overflow_events, fault    status
module rx_drain_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 2**24,
  parameter int unsigned ADDR_W         = 48
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              run,
  input  logic              stop_on_overflow,
  input  logic [ADDR_W-1:0] buffer_base_address,
  input  logic [31:0]       buffer_size,
  input  logic [16:0]       buffer_packet_size_bytes,
  output logic              write_enable,
  input  logic [2:0]        write_state,
  input  logic              buffer_empty,
  input  logic              buffer_overflow,
  input  logic [31:0]       buffer_occupation,
  output logic              buffer_packet_tick,
  input  logic              buffer_packet_tick_ack,
  output logic              xfer_req_valid,
  input  logic              xfer_req_ready,
  output logic [ADDR_W-1:0] xfer_req_addr,
  output logic [16:0]       xfer_req_len,
  input  logic              xfer_done,
  input  logic              xfer_err,
  output logic [2:0]        sched_state,
  output logic [31:0]       read_offset,
  output logic [31:0]       packets_sent,
  output logic [31:0]       overflow_events,
  output logic              fault
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REQ   = 3'd2,
    S_XFER  = 3'd3,
    S_TICK  = 3'd4,
    S_STOPW = 3'd5,
    S_DRAIN = 3'd6,
    S_FAULT = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                tick_q, tick_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [16:0]         len_q, len_d;
  logic [31:0]         offset_q, offset_d;
  logic [31:0]         pkts_q, pkts_d;
  logic [31:0]         ovf_cnt_q, ovf_cnt_d;
  logic                fault_q, fault_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [32:0]         offset_sum;

  // Next read offset after retiring one packet; geometry guarantees an exact wrap.
  assign offset_sum = 33'(offset_q) + 33'(len_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    addr_d     = addr_q;
    len_d      = len_q;
    offset_d   = offset_q;
    pkts_d     = pkts_q;
    timer_d    = timer_q;
    ovf_cnt_d  = ovf_cnt_q;
    ovf_flag_d = ovf_flag_q | (buffer_overflow & stop_on_overflow);

    if (buffer_overflow && (ovf_cnt_q != 32'hFFFF_FFFF)) ovf_cnt_d = ovf_cnt_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (run && (write_state == 3'd0)) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Flag is registered, so an overflow in the same cycle as a request decision
        // only takes effect at the next visit to WAIT.
        if (!run) begin
          state_d = S_IDLE;
        end else if (ovf_flag_q && stop_on_overflow) begin
          state_d = S_STOPW;
        end else if (!buffer_empty) begin
          addr_d  = buffer_base_address + ADDR_W'(offset_q);
          len_d   = buffer_packet_size_bytes;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Accepted request is committed even if run drops in the same cycle.
        if (xfer_req_ready) begin
          timer_d = '0;
          state_d = S_XFER;
        end else if (!run) begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (xfer_done) begin
          state_d = xfer_err ? S_FAULT : S_TICK;
          tick_d  = !xfer_err;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_TICK: begin
        if (tick_q) begin
          if (buffer_packet_tick_ack) tick_d = 1'b0;
        end else if (!buffer_packet_tick_ack) begin
          pkts_d   = pkts_q + 32'd1;
          offset_d = (offset_sum >= 33'(buffer_size)) ? 32'd0 : offset_sum[31:0];
          state_d  = S_WAIT;
        end
      end
      S_STOPW: begin
        if (write_state == 3'd0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Discard ticks; occupation is only trusted between handshakes.
        if (tick_q) begin
          if (buffer_packet_tick_ack) tick_d = 1'b0;
        end else if (!buffer_packet_tick_ack) begin
          if (buffer_occupation == 32'd0) begin
            offset_d   = 32'd0;
            ovf_flag_d = 1'b0;
            state_d    = run ? S_WAIT : S_IDLE;
          end else if (!run) begin
            ovf_flag_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tick_d = 1'b1;
          end
        end
      end
      S_FAULT: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_REQ);
    we_d    = (state_d == S_WAIT) || (state_d == S_REQ) ||
              (state_d == S_XFER) || (state_d == S_TICK);
    fault_d = (state_d == S_FAULT);
    if (state_d == S_IDLE) offset_d = 32'd0;
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      offset_q   <= '0;
      pkts_q     <= '0;
      ovf_cnt_q  <= '0;
      fault_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      tick_q     <= tick_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      offset_q   <= offset_d;
      pkts_q     <= pkts_d;
      ovf_cnt_q  <= ovf_cnt_d;
      fault_q    <= fault_d;
      ovf_flag_q <= ovf_flag_d;
      timer_q    <= timer_d;
    end
  end

  assign sched_state        = state_q;
  assign write_enable       = we_q;
  assign buffer_packet_tick = tick_q;
  assign xfer_req_valid     = valid_q;
  assign xfer_req_addr      = addr_q;
  assign xfer_req_len       = len_q;
  assign read_offset        = offset_q;
  assign packets_sent       = pkts_q;
  assign overflow_events    = ovf_cnt_q;
  assign fault              = fault_q;

endmodule

// File: doc/rx_drain_sched.md
Name: rx_drain_sched

Overview:
- Host-side scheduler for the RX DDR ring buffer filled by the RX DMA write engine.
- Enables the write engine and tracks the ring read pointer.
- Issues one packet-sized read request per available packet to the downstream DMA (USB 3.0 path), then retires each packet with the buffer_packet_tick / ack handshake.
- On overflow, optionally stops the writer, discards the ring, re-aligns read and write pointers to base, and restarts.

Parameters:
- TIMEOUT_CYCLES, 2**24: max cycles from xfer request accept to xfer_done before FAULT.
- ADDR_W, 48: DDR address width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = stream, 0 = stop after in-flight packet.
- stop_on_overflow  in  1  1 = recover on overflow; 0 = count overflow and continue.
- buffer_base_address  in  ADDR_W  ring base address.
- buffer_size  in  32  ring bytes; must be an integer multiple of buffer_packet_size_bytes.
- buffer_packet_size_bytes  in  17  bytes per packet (16-byte multiple, nonzero).
- write_enable  out  1  to write engine.
- write_state  in  3  from write engine; 0 = idle.
- buffer_empty  in  1  from write engine.
- buffer_overflow  in  1  from write engine; one-cycle pulse.
- buffer_occupation  in  32  from write engine.
- buffer_packet_tick  out  1  to write engine.
- buffer_packet_tick_ack  in  1  from write engine.
- xfer_req_valid  out  1  DMA request valid.
- xfer_req_ready  in  1  DMA request ready.
- xfer_req_addr  out  ADDR_W  packet address.
- xfer_req_len  out  17  packet bytes.
- xfer_done  in  1  one-cycle completion pulse.
- xfer_err  in  1  qualifies xfer_done.
- sched_state  out  3  current state encoding.
- read_offset  out  32  ring read offset.
- packets_sent  out  32  packets retired.
- overflow_events  out  32  overflow pulses seen.
- fault  out  1  sticky until reset or run = 0.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; sched_state = IDLE (0).
- States: IDLE = 0, WAIT = 1, REQ = 2, XFER = 3, TICK = 4, STOPW = 5, DRAIN = 6, FAULT = 7.
- IDLE:
  - write_enable = 0.
  - read_offset = 0.
  - Go to WAIT when run = 1 and write_state == 0.
  - write_enable rises on entry to WAIT.
- WAIT:
  - If run = 0: go to IDLE. write_enable falls the same cycle.
  - Else if buffer_empty = 0: latch xfer_req_addr = buffer_base_address + read_offset, latch xfer_req_len = buffer_packet_size_bytes, go to REQ.
- REQ:
  - xfer_req_valid = 1, held stable until xfer_req_ready.
  - On the handshake cycle: valid falls next cycle, timeout counter clears, go to XFER.
- XFER:
  - Ignores run.
  - xfer_done with xfer_err = 0: go to TICK.
  - xfer_done with xfer_err = 1: go to FAULT.
  - Counter reaches TIMEOUT_CYCLES - 1: go to FAULT.
- TICK (4-phase handshake):
  - Assert buffer_packet_tick; hold until buffer_packet_tick_ack = 1; then deassert.
  - Wait for ack = 0 before leaving.
  - On exit: packets_sent += 1; read_offset += len, wrapping to 0 when the sum ≥ buffer_size (buffer_size is an exact multiple, so no remainder).
  - Go to WAIT.
  - Ignores run.
- Overflow:
  - Any cycle with buffer_overflow = 1 increments overflow_events (saturating at 2^32 - 1).
  - In WAIT with stop_on_overflow = 1 and an overflow seen since the last WAIT entry (sticky flag): go to STOPW.
  - The flag is cleared on DRAIN exit.
- STOPW:
  - write_enable = 0.
  - Wait write_state == 0 (writer re-arms its address to base).
  - Go to DRAIN.
- DRAIN:
  - Issue discard ticks (same 4-phase handshake, no xfer request, packets_sent unchanged) until buffer_occupation == 0 is sampled with tick = 0 and ack = 0.
  - Then: read_offset = 0, write_enable = 1, go to WAIT.
  - If run = 0 during DRAIN: finish the current tick, then go to IDLE.
- FAULT:
  - fault = 1, write_enable = 0, no requests or ticks.
  - Leave only when run = 0: go to IDLE, fault clears.
- Simultaneous events:
  - buffer_overflow in the same cycle as the WAIT → REQ decision: REQ wins; the flag is acted on at the next WAIT.
  - run falling in REQ before handshake: drop valid, go to IDLE (request is not committed until accepted).
- Never more than one outstanding request; never a tick without a completed transfer, except in DRAIN.
- Asynchronous reset mid-operation: immediate return to reset values; an in-flight DMA transfer is abandoned.

Test Plan:
- Basic stream:
  - Config: buffer_size = 0x40000, pkt = 0x10000, run = 1; writer model fills the ring.
  - Required: 4 requests at base+0, +0x10000, +0x20000, +0x30000; 5th request at base+0; packets_sent = 5.
- Tick handshake:
  - Delay ack by 7 cycles, and ack release by 3 cycles.
  - Required: tick stays high exactly until ack; no next request until ack = 0.
- Overflow recovery:
  - stop_on_overflow = 1; inject an overflow pulse; occupation = 0x18000.
  - Required: write_enable drops; 2 discard ticks until occupation = 0; read_offset = 0; write_enable = 1; overflow_events = 1; packets_sent unchanged.
- Error and timeout:
  - xfer_done with xfer_err = 1 → fault = 1, write_enable = 0.
  - With TIMEOUT_CYCLES = 100 and no done → FAULT at cycle 100.
  - run = 0 → IDLE, fault = 0.
- Stop and reset:
  - run = 0 during XFER → tick completes, then IDLE.
  - run = 0 in REQ before ready → valid drops, no tick.
  - aresetn low mid-TICK → all outputs 0 asynchronously.
